// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: access-size codes, FSM states, captured request.
package mem_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SETUP    = 2'b01,
        WAIT_MOC = 2'b10,
        RESPOND  = 2'b11
    } state_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  typ;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational alignment check, write-data justification and read-data extension.
// Zero latency; no flow control.
module mem_align_unit
    import mem_pkg::*;
(
    input  logic [1:0]  typ_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sgn_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic        legal_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        legal_o = 1'b0;
        wdata_o = wdata_i;
        rdata_o = rdata_raw_i;
        case (typ_i)
            TYPE_BYTE: begin
                legal_o = 1'b1;
                wdata_o = {24'b0, wdata_i[7:0]};
                rdata_o = {{24{sgn_i & rdata_raw_i[7]}}, rdata_raw_i[7:0]};
            end
            TYPE_HALF: begin
                legal_o = ~addr_lo_i[0];
                wdata_o = {16'b0, wdata_i[15:0]};
                rdata_o = {{16{sgn_i & rdata_raw_i[15]}}, rdata_raw_i[15:0]};
            end
            TYPE_WORD: begin
                legal_o = (addr_lo_i == 2'b00);
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access controller: IDLE -> SETUP -> WAIT_MOC -> RESPOND, with timeout.
// Best case 3 cycles from accept to rsp_valid; requests outside IDLE are dropped (req_ready low).
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_type,
    input  logic        req_signed,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  mem_address,
    output logic [31:0] mem_datain,
    output logic        mem_rw,
    output logic [1:0]  mem_typedata,
    output logic        mem_mv,
    input  logic        mem_moc,
    input  logic [31:0] mem_dataout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    state_t          state_q;
    req_t            cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q;
    logic            req_ready_q, rsp_valid_q, rsp_err_q, mem_mv_q, mem_rw_q;
    logic [31:0]     rsp_rdata_q, mem_datain_q;
    logic [7:0]      mem_address_q;
    logic [1:0]      mem_typedata_q;
    logic            legal;
    logic [31:0]     wdata_just, rdata_ext;

    // The align unit sees the request being captured in IDLE, and the held request afterwards.
    always_comb begin
        cap_d = cap_q;
        if (state_q == IDLE && req) begin
            cap_d = '{rw: req_rw, typ: req_type, sgn: req_signed, addr: req_addr, wdata: req_wdata};
        end
    end

    mem_align_unit u_align (
        .typ_i       (cap_d.typ),
        .addr_lo_i   (cap_d.addr[1:0]),
        .sgn_i       (cap_d.sgn),
        .wdata_i     (cap_d.wdata),
        .rdata_raw_i (mem_dataout),
        .legal_o     (legal),
        .wdata_o     (wdata_just),
        .rdata_o     (rdata_ext)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cap_q          <= '0;
            cnt_q          <= '0;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= '0;
            mem_address_q  <= '0;
            mem_datain_q   <= '0;
            mem_rw_q       <= 1'b0;
            mem_typedata_q <= '0;
            mem_mv_q       <= 1'b0;
        end else begin
            cap_q       <= cap_d;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        req_ready_q <= 1'b0;
                        if (legal) begin
                            state_q        <= SETUP;
                            mem_address_q  <= req_addr;
                            mem_rw_q       <= req_rw;
                            mem_typedata_q <= req_type;
                            mem_datain_q   <= wdata_just;
                        end else begin
                            state_q     <= RESPOND;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                SETUP: begin
                    state_q  <= WAIT_MOC;
                    mem_mv_q <= 1'b1;
                    cnt_q    <= '0;
                end
                WAIT_MOC: begin
                    // A completion on the final counted cycle wins over the timeout.
                    if (mem_moc) begin
                        state_q     <= RESPOND;
                        mem_mv_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= cap_q.rw ? rdata_ext : 32'h0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q     <= RESPOND;
                        mem_mv_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        cnt_q       <= CNT_SAT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESPOND: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    mem_mv_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign mem_address  = mem_address_q;
    assign mem_datain   = mem_datain_q;
    assign mem_rw       = mem_rw_q;
    assign mem_typedata = mem_typedata_q;
    assign mem_mv       = mem_mv_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs driven and outputs sampled on the falling clock edge.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk, reset_n;
    logic        req, req_ready, req_rw, req_signed;
    logic [1:0]  req_type;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  mem_address;
    logic [31:0] mem_datain;
    logic        mem_rw, mem_mv, mem_moc;
    logic [1:0]  mem_typedata;
    logic [31:0] mem_dataout;

    int errors = 0;
    int checks = 0;

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_ready(req_ready),
        .req_rw(req_rw), .req_type(req_type), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_datain(mem_datain), .mem_rw(mem_rw),
        .mem_typedata(mem_typedata), .mem_mv(mem_mv),
        .mem_moc(mem_moc), .mem_dataout(mem_dataout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic drive_req(input logic rw, input logic [1:0] t, input logic s,
                             input logic [7:0] a, input logic [31:0] wd);
        req = 1'b1; req_rw = rw; req_type = t; req_signed = s; req_addr = a; req_wdata = wd;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if ({mem_mv, rsp_valid, rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got mv/valid/err=%b want 000", {mem_mv, rsp_valid, rsp_err}); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        checks++; if ({mem_address, mem_datain, mem_rw, mem_typedata} !== 43'h0) begin errors++; $display("FAIL reset_mem: got addr=%h din=%h rw=%b type=%b want all 0", mem_address, mem_datain, mem_rw, mem_typedata); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if ({req_ready, mem_mv, rsp_valid} !== 3'b100) begin errors++; $display("FAIL reset_release: got ready/mv/valid=%b want 100", {req_ready, mem_mv, rsp_valid}); end
    endtask

    task automatic test_write(input logic [1:0] t, input logic [7:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_din, input string nm);
        drive_req(1'b0, t, 1'b0, a, wd);
        mem_moc = 1'b1;
        @(negedge clk); req = 1'b0;
        checks++; if ({req_ready, mem_mv, rsp_valid} !== 3'b000) begin errors++; $display("FAIL %s_setup_flags: got ready/mv/valid=%b want 000", nm, {req_ready, mem_mv, rsp_valid}); end
        checks++; if (mem_datain !== exp_din) begin errors++; $display("FAIL %s_datain: got %h want %h", nm, mem_datain, exp_din); end
        checks++; if ({mem_address, mem_rw, mem_typedata} !== {a, 1'b0, t}) begin errors++; $display("FAIL %s_mem_ctl: got addr=%h rw=%b type=%b want %h 0 %b", nm, mem_address, mem_rw, mem_typedata, a, t); end
        @(negedge clk);
        checks++; if ({req_ready, mem_mv, rsp_valid} !== 3'b010) begin errors++; $display("FAIL %s_wait_flags: got ready/mv/valid=%b want 010", nm, {req_ready, mem_mv, rsp_valid}); end
        @(negedge clk);
        checks++; if ({req_ready, mem_mv, rsp_valid, rsp_err} !== 4'b0010) begin errors++; $display("FAIL %s_rsp_flags: got ready/mv/valid/err=%b want 0010", nm, {req_ready, mem_mv, rsp_valid, rsp_err}); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL %s_rsp_rdata: got %h want 0", nm, rsp_rdata); end
        mem_moc = 1'b0;
        @(negedge clk);
        checks++; if ({req_ready, mem_mv, rsp_valid} !== 3'b100) begin errors++; $display("FAIL %s_idle_flags: got ready/mv/valid=%b want 100", nm, {req_ready, mem_mv, rsp_valid}); end
    endtask

    task automatic test_read(input logic [1:0] t, input logic s, input logic [7:0] a,
                             input logic [31:0] dout, input logic [31:0] exp, input string nm);
        drive_req(1'b1, t, s, a, 32'hA5A5_A5A5);
        mem_moc = 1'b0; mem_dataout = dout;
        @(negedge clk); req = 1'b0;
        checks++; if ({mem_mv, mem_address, mem_rw, mem_typedata} !== {1'b0, a, 1'b1, t}) begin errors++; $display("FAIL %s_setup: got mv=%b addr=%h rw=%b type=%b want 0 %h 1 %b", nm, mem_mv, mem_address, mem_rw, mem_typedata, a, t); end
        @(negedge clk);
        checks++; if ({mem_mv, rsp_valid} !== 2'b10) begin errors++; $display("FAIL %s_wait: got mv/valid=%b want 10", nm, {mem_mv, rsp_valid}); end
        mem_moc = 1'b1;
        @(negedge clk);
        mem_moc = 1'b0; mem_dataout = 32'h5555_5555;
        checks++; if ({mem_mv, rsp_valid, rsp_err} !== 3'b010) begin errors++; $display("FAIL %s_rsp_flags: got mv/valid/err=%b want 010", nm, {mem_mv, rsp_valid, rsp_err}); end
        checks++; if (rsp_rdata !== exp) begin errors++; $display("FAIL %s_rdata: got %h want %h", nm, rsp_rdata, exp); end
        @(negedge clk);
        checks++; if ({req_ready, rsp_valid, rsp_rdata} !== {2'b10, exp}) begin errors++; $display("FAIL %s_hold: got ready/valid=%b rdata=%h want 10 %h", nm, {req_ready, rsp_valid}, rsp_rdata, exp); end
    endtask

    task automatic test_illegal(input logic [1:0] t, input logic [7:0] a, input string nm);
        drive_req(1'b1, t, 1'b0, a, 32'h0);
        mem_moc = 1'b1;
        @(negedge clk); req = 1'b0;
        checks++; if ({req_ready, mem_mv, rsp_valid, rsp_err} !== 4'b0011) begin errors++; $display("FAIL %s_rsp: got ready/mv/valid/err=%b want 0011", nm, {req_ready, mem_mv, rsp_valid, rsp_err}); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL %s_rdata: got %h want 0", nm, rsp_rdata); end
        @(negedge clk);
        checks++; if ({req_ready, mem_mv, rsp_valid, rsp_err} !== 4'b1001) begin errors++; $display("FAIL %s_after: got ready/mv/valid/err=%b want 1001", nm, {req_ready, mem_mv, rsp_valid, rsp_err}); end
        mem_moc = 1'b0;
    endtask

    task automatic test_timeout;
        int mv_cycles = 0;
        bit got = 0;
        drive_req(1'b1, TYPE_WORD, 1'b0, 8'h08, 32'h0);
        mem_moc = 1'b0; mem_dataout = 32'hFFFF_FFFF;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk); req = 1'b0;
            if (mem_mv) mv_cycles++;
            if (rsp_valid) got = 1;
        end
        checks++; if (!got) begin errors++; $display("FAIL timeout_rsp: got no rsp_valid within 40 cycles, want one"); end
        checks++; if (mv_cycles != 15) begin errors++; $display("FAIL timeout_mv_cycles: got %0d want 15", mv_cycles); end
        checks++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL timeout_err: got err=%b rdata=%h want 1 0", rsp_err, rsp_rdata); end
        @(negedge clk);
        checks++; if ({req_ready, mem_mv, rsp_valid} !== 3'b100) begin errors++; $display("FAIL timeout_idle: got ready/mv/valid=%b want 100", {req_ready, mem_mv, rsp_valid}); end
    endtask

    task automatic test_moc_at_limit;
        int mv_cycles = 0;
        drive_req(1'b1, TYPE_WORD, 1'b0, 8'h0C, 32'h0);
        mem_moc = 1'b0; mem_dataout = 32'h1357_9BDF;
        for (int k = 0; k < 40 && mv_cycles < 15; k++) begin
            @(negedge clk); req = 1'b0;
            if (mem_mv) mv_cycles++;
        end
        checks++; if (mv_cycles != 15) begin errors++; $display("FAIL limit_reach: got %0d mv cycles want 15", mv_cycles); end
        mem_moc = 1'b1;
        @(negedge clk);
        mem_moc = 1'b0;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1357_9BDF}) begin errors++; $display("FAIL limit_success: got valid/err=%b rdata=%h want 10 13579bdf", {rsp_valid, rsp_err}, rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        drive_req(1'b1, TYPE_WORD, 1'b0, 8'h30, 32'h0);
        mem_moc = 1'b0;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        checks++; if (mem_mv !== 1'b1) begin errors++; $display("FAIL rstmid_wait: got mv=%b want 1", mem_mv); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if ({mem_mv, req_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_async: got mv/ready=%b want 01", {mem_mv, req_ready}); end
        @(negedge clk); reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid || mem_mv) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_rsp: got rsp_valid/mem_mv after abort, want none"); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp;
        drive_req(1'b0, TYPE_WORD, 1'b0, 8'h20, 32'hCAFE_F00D);
        mem_moc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            case (k % 4)
                0: exp = 3'b100;
                2: exp = 3'b010;
                3: exp = 3'b001;
                default: exp = 3'b000;
            endcase
            checks++; if ({req_ready, mem_mv, rsp_valid} !== exp) begin errors++; $display("FAIL b2b_cycle%0d: got ready/mv/valid=%b want %b", k, {req_ready, mem_mv, rsp_valid}, exp); end
            if (k == 1) begin
                checks++; if (mem_address !== 8'h20) begin errors++; $display("FAIL b2b_addr1: got %h want 20", mem_address); end
            end
            if (k == 5) begin
                checks++; if (mem_address !== 8'h24) begin errors++; $display("FAIL b2b_addr2: got %h want 24", mem_address); end
            end
            if (k == 2) req_addr = 8'h24;
        end
        req = 1'b0; mem_moc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; req_rw = 1'b0; req_type = 2'b00; req_signed = 1'b0;
        req_addr = 8'h0; req_wdata = 32'h0; mem_moc = 1'b0; mem_dataout = 32'h0;
        test_reset;
        test_write(TYPE_WORD, 8'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "word_wr");
        test_read(TYPE_BYTE, 1'b1, 8'h03, 32'h0000_0080, 32'hFFFF_FF80, "byte_rd_s");
        test_read(TYPE_BYTE, 1'b0, 8'h03, 32'h0000_0080, 32'h0000_0080, "byte_rd_u");
        test_write(TYPE_BYTE, 8'h11, 32'h1234_5678, 32'h0000_0078, "byte_wr");
        test_read(TYPE_HALF, 1'b1, 8'h02, 32'hABCD_8001, 32'hFFFF_8001, "half_rd_s");
        test_read(TYPE_HALF, 1'b0, 8'h06, 32'hABCD_8001, 32'h0000_8001, "half_rd_u");
        test_write(TYPE_HALF, 8'h22, 32'h1234_5678, 32'h0000_5678, "half_wr");
        test_read(TYPE_WORD, 1'b1, 8'h04, 32'h89AB_CDEF, 32'h89AB_CDEF, "word_rd");
        test_illegal(TYPE_HALF, 8'h05, "half_misalign");
        test_illegal(2'b11, 8'h04, "type11");
        test_illegal(TYPE_WORD, 8'h06, "word_misalign");
        test_read(TYPE_BYTE, 1'b1, 8'h01, 32'h0000_00F0, 32'hFFFF_FFF0, "byte_rd_pre");
        test_timeout;
        test_moc_at_limit;
        test_reset_mid;
        test_read(TYPE_WORD, 1'b0, 8'h08, 32'h0000_1234, 32'h0000_1234, "after_reset");
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
